// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and counter encodings for the branch predictor
package bp_pkg;

  localparam int BP_ENTRIES = 16;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

endpackage

// File: rtl/bht_counter.sv
// rtl/bht_counter.sv - 2-bit saturating direction counter next-state logic
module bht_counter
  import bp_pkg::*;
(
  input  ctr_e state_i,
  input  logic taken_i,
  output ctr_e next_o
);

  always_comb begin
    next_o = state_i;
    unique case (state_i)
      SNT: next_o = taken_i ? WNT : SNT;
      WNT: next_o = taken_i ? WT  : SNT;
      WT:  next_o = taken_i ? ST  : WNT;
      ST:  next_o = taken_i ? ST  : WT;
      default: next_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit BHT, combinational lookup
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pf_pc,
  output logic [31:0] target_address_final,
  output logic        predict_final,
  input  logic        upd_valid,
  input  logic        upd_stall,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] hit_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];
  logic [31:0]        hit_count_q;
  logic [31:0]        hit_count_d;

  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic [IW-1:0] up_idx;
  logic [TW-1:0] up_tag;
  logic          up_hit;
  logic          up_commit;
  ctr_e          ctr_d;

  // Low two PC bits never take part in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pf_pc[1:0], upd_pc[1:0]};

  assign lk_idx = pf_pc[IW+1:2];
  assign lk_tag = pf_pc[31:IW+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign predict_final        = lk_hit && (ctr_q[lk_idx] inside {WT, ST});
  assign target_address_final = predict_final ? target_q[lk_idx] : pf_pc + 32'd4;

  assign up_idx    = upd_pc[IW+1:2];
  assign up_tag    = upd_pc[31:IW+2];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_commit = upd_valid && !upd_stall;

  bht_counter u_bht_counter (
    .state_i (ctr_q[up_idx]),
    .taken_i (upd_taken),
    .next_o  (ctr_d)
  );

  assign hit_count_d = hit_count_q + 32'd1;
  assign hit_count   = hit_count_q;

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= '0;
      hit_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else if (up_commit) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_d;
        hit_count_q   <= hit_count_d;
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule
